// File: rtl/slot_pkg.sv
// slot_pkg: shared types and constants for the slot machine blocks
package slot_pkg;
  typedef enum logic [1:0] {IDLE, SPIN_UP, SPINNING, SPIN_DOWN} reel_seq_state_t;
  localparam int STAGGER_HW = 12_500_000;
  localparam int STAGGER_SIM = 4;
endpackage

// File: rtl/stagger_timer.sv
// stagger_timer: counts clk cycles between reel events, ticks at STAGGER-1
module stagger_timer #(
  parameter int STAGGER = 4,
  parameter int CNT_W = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (!rst || clr) ? '0 : en ? cnt + 1'b1 : cnt;
  assign tick = cnt == CNT_W'(STAGGER - 1);
endmodule

// File: rtl/reel_sequencer.sv
// reel_sequencer: staggers per-reel spin enables on run/stop requests
module reel_sequencer
  import slot_pkg::*;
#(
  parameter int NUM_REELS = 3,
  parameter int STAGGER = STAGGER_HW,
  parameter int CNT_W = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 runReq,
  output logic [NUM_REELS-1:0] reelEn,
  output logic                 busy,
  output logic                 allStopped,
  output logic                 stopDone
);
  localparam int IW = $clog2(NUM_REELS);
  reel_seq_state_t state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [NUM_REELS-1:0] en_nxt, sel;
  logic sd_nxt, tick, clr, last;
  stagger_timer #(.STAGGER(STAGGER), .CNT_W(CNT_W)) u_timer (
    .clk(clk), .rst(rst), .clr(clr), .en(busy), .tick(tick)
  );
  assign busy = state == SPIN_UP || state == SPIN_DOWN;
  assign allStopped = state == IDLE;
  assign last = idx == IW'(NUM_REELS - 1);
  assign sel = NUM_REELS'(1) << idx;
  // An abort restarts the slot timing from index 0, so the counter clears too.
  assign clr = !busy || tick || (state == SPIN_UP && !runReq);
  always_comb begin
    state_nxt = state;
    en_nxt = reelEn;
    idx_nxt = idx;
    sd_nxt = 1'b0;
    case (state)
      IDLE: if (runReq) begin
        state_nxt = SPIN_UP;
        en_nxt = NUM_REELS'(1);
        idx_nxt = IW'(1);
      end
      SPIN_UP: if (!runReq) begin
        state_nxt = SPIN_DOWN;
        en_nxt = reelEn & ~NUM_REELS'(1);
        idx_nxt = IW'(1);
      end else if (tick) begin
        en_nxt = reelEn | sel;
        idx_nxt = last ? '0 : idx + 1'b1;
        state_nxt = last ? SPINNING : SPIN_UP;
      end
      SPINNING: if (!runReq) begin
        state_nxt = SPIN_DOWN;
        en_nxt = reelEn & ~NUM_REELS'(1);
        idx_nxt = IW'(1);
      end
      default: if (tick) begin
        en_nxt = reelEn & ~sel;
        idx_nxt = last ? '0 : idx + 1'b1;
        state_nxt = last ? IDLE : SPIN_DOWN;
        sd_nxt = last;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      reelEn <= '0;
      idx <= '0;
      stopDone <= 1'b0;
    end else begin
      state <= state_nxt;
      reelEn <= en_nxt;
      idx <= idx_nxt;
      stopDone <= sd_nxt;
    end
  end
endmodule

// File: tb/tb_reel_sequencer.sv
// tb_reel_sequencer: directed scoreboard bench for reel_sequencer (3 reels, stagger 4)
module tb_reel_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic runReq = 1'b0;
  logic [2:0] reelEn;
  logic busy, allStopped, stopDone;
  logic [5:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  reel_sequencer #(.NUM_REELS(3), .STAGGER(4), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .runReq(runReq), .reelEn(reelEn),
    .busy(busy), .allStopped(allStopped), .stopDone(stopDone)
  );

  always #5 clk = ~clk;

  // expected word: {reelEn[2:0], busy, allStopped, stopDone}
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [5:0] e, a;
      e = exp_q.pop_front();
      a = {reelEn, busy, allStopped, stopDone};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_check #%0d: got en=%b busy=%b all=%b sd=%b, want en=%b busy=%b all=%b sd=%b",
                 checks, a[5:3], a[2], a[1], a[0], e[5:3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic step(input int n, input logic r, input logic q, input logic [5:0] e);
    for (int i = 0; i < n; i++) begin
      rst = r;
      runReq = q;
      @(posedge clk);
      exp_q.push_back(e);
      #1;
    end
  endtask

  localparam logic [5:0] IDL = 6'b000_010;
  localparam logic [5:0] SD  = 6'b000_011;

  initial begin
    // reset with runReq high
    step(2, 0, 1, IDL);
    step(3, 1, 0, IDL);
    // full start then full stop
    step(4, 1, 1, 6'b001_100);
    step(4, 1, 1, 6'b011_100);
    step(3, 1, 1, 6'b111_000);
    step(4, 1, 0, 6'b110_100);
    step(4, 1, 0, 6'b100_100);
    step(1, 1, 0, SD);
    step(2, 1, 0, IDL);
    // abort during spin-up with two reels running
    step(4, 1, 1, 6'b001_100);
    step(1, 1, 1, 6'b011_100);
    step(4, 1, 0, 6'b010_100);
    step(4, 1, 0, 6'b000_100);
    step(1, 1, 0, SD);
    step(1, 1, 0, IDL);
    // restart requested during spin-down
    step(4, 1, 1, 6'b001_100);
    step(4, 1, 1, 6'b011_100);
    step(2, 1, 1, 6'b111_000);
    step(4, 1, 0, 6'b110_100);
    step(4, 1, 1, 6'b100_100);
    step(1, 1, 1, SD);
    step(1, 1, 1, 6'b001_100);
    // immediate abort: full walk over never-enabled reels
    step(8, 1, 0, 6'b000_100);
    step(1, 1, 0, SD);
    step(1, 1, 0, IDL);
    // mid-sequence reset
    step(4, 1, 1, 6'b001_100);
    step(1, 1, 1, 6'b011_100);
    step(1, 0, 1, IDL);
    step(2, 1, 0, IDL);
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reel_sequencer.md
# reel_sequencer

Sequences the spinning reels of the slot machine so they start and stop one after another instead of all at once. It sits between the slot game FSM's run request and the per-reel digit counters, and turns a single run/stop level into one enable per reel. Reels are staggered by a programmable delay. It reports when every reel has come to rest so the game FSM evaluates a win only on settled digits.

## Interface
- `NUM_REELS`, 3: number of reels; each reel drives one digit pair. Legal range is 2..8.
- `STAGGER`, 12_500_000: clk cycles between successive reel start or stop events. Set to 4 for simulation. Must be ≥ 1.
- `CNT_W`, 24: width of the stagger counter. Must satisfy 2^CNT_W > STAGGER.
- `clk`  in  1  FPGA system clock. All logic is clocked on its rising edge.
- `rst`  in  1  synchronous reset, active-low.
- `runReq`  in  1  level from the game FSM: 1 = reels should spin, 0 = reels should stop. Sampled every cycle.
- `reelEn`  out  NUM_REELS  per-reel spin enable. Bit i drives reel i's counter enable.
- `busy`  out  1  high while a start or stop sequence is in progress.
- `allStopped`  out  1  high when every reel enable is 0 and no sequence is active.
- `stopDone`  out  1  one-cycle pulse when a stop sequence completes.

## Operation
- Reset (`rst`=0 at a rising edge):
  - state goes to IDLE; `reelEn`=0, `busy`=0, `allStopped`=1, `stopDone`=0; counter and reel index cleared.
  - Reset mid-sequence drops every enable immediately and does not pulse `stopDone`.
- IDLE:
  - `runReq`=1 → SPIN_UP. In the same edge, set `reelEn[0]`, index=1, counter=0.
- SPIN_UP:
  - Counter increments each cycle.
  - When counter = STAGGER-1: set `reelEn[index]`, index++, counter=0.
  - Setting bit NUM_REELS-1 → SPINNING in the same edge.
- SPINNING:
  - All enables are high.
  - `runReq`=0 → SPIN_DOWN. In the same edge, clear `reelEn[0]`, index=1, counter=0.
- SPIN_DOWN:
  - Same cadence as SPIN_UP, but each step clears `reelEn[index]`.
  - The stop walk always covers all NUM_REELS indices in order, even if a reel was never enabled, so stop duration is fixed.
  - Clearing bit NUM_REELS-1 → IDLE in the same edge, with `stopDone`=1 for the following cycle.
- `runReq` falls during SPIN_UP:
  - Abort immediately to SPIN_DOWN from index 0 (clears `reelEn[0]` that edge).
  - Reels already enabled are stopped in order; indices never enabled still consume their STAGGER slot.
- `runReq` rises during SPIN_DOWN:
  - Ignored; the stop sequence always completes.
  - If `runReq` is still 1 when IDLE is reached, SPIN_UP starts on the next edge (IDLE is held for exactly one cycle).
- Output decode:
  - `busy` = SPIN_UP or SPIN_DOWN.
  - `allStopped` = IDLE.
  - `stopDone` is registered.

## Timing
- Start latency: `runReq` sampled high in IDLE at edge k → `reelEn[0]`=1 after edge k. `reelEn[i]` rises after edge k + i·STAGGER.
- Stop latency: `runReq` sampled low in SPINNING at edge m → `reelEn[i]` falls after edge m + i·STAGGER. IDLE and `allStopped`=1 after edge m + (NUM_REELS-1)·STAGGER; `stopDone` is high during that same cycle only.
- STAGGER=1 degenerates to one reel per cycle. No extra wait states.
- The counter never wraps: it is cleared at STAGGER-1 and held at 0 in IDLE and SPINNING.

## Structure
- Shared package `slot_pkg` holds:
  - `reel_seq_state_t` enum {IDLE, SPIN_UP, SPINNING, SPIN_DOWN};
  - `STAGGER_HW` = 12_500_000 and `STAGGER_SIM` = 4.
- Sub-module `stagger_timer` (CNT_W-bit counter with synchronous clear/enable) outputs a `tick` when count = STAGGER-1. `reel_sequencer` owns the FSM and the reel index.

## Test plan
All scenarios use NUM_REELS=3 and STAGGER=4.
- Reset: hold `rst`=0 for 2 cycles, with `runReq`=1 → `reelEn`=000, `allStopped`=1, `busy`=0, `stopDone`=0 throughout.
- Full start: `runReq`↑ at edge 10 →
  - `reelEn`=001 after edge 10, 011 after edge 14, 111 after edge 18;
  - `busy` high from edge 10 to edge 18, then low.
- Full stop: from SPINNING, `runReq`↓ at edge 30 →
  - `reelEn`=110 after edge 30, 100 after edge 34, 000 after edge 38;
  - `stopDone` high for exactly the cycle after edge 38.
- Abort: `runReq`↑ at edge 10, ↓ at edge 15 (`reelEn`=011) →
  - `reelEn`=010 after edge 15, 000 after edge 19;
  - IDLE after edge 23, `stopDone` pulse.
- Restart during stop: `runReq`↑ again during SPIN_DOWN → no change to the stop walk; one IDLE cycle, then `reelEn`=001 on the next edge.
- Mid-sequence reset: `rst`=0 while `reelEn`=011 → 000 after that edge, no `stopDone`, IDLE.
